// File: rtl/blit_loop_sequencer_if.sv
// ---------------------------------------------------------------------------
// blit_loop_sequencer_if
// Handshake bundle between the blitter command side, the loop sequencer and
// the address/data step datapath.
//
// Command/datapath side (master) drives:
//   start, inner_cnt, outer_cnt, step_ack, abort
// Sequencer side (slave) drives:
//   step_req, inner_ld, inner_last, outer_last, busy, done, irq
// ---------------------------------------------------------------------------
interface blit_loop_sequencer_if #(
    parameter int INNER_W = 9,
    parameter int OUTER_W = 8
);
    logic               start;
    logic [INNER_W-1:0] inner_cnt;
    logic [OUTER_W-1:0] outer_cnt;
    logic               step_ack;
    logic               abort;
    logic               step_req;
    logic               inner_ld;
    logic               inner_last;
    logic               outer_last;
    logic               busy;
    logic               done;
    logic               irq;

    modport master (
        output start, inner_cnt, outer_cnt, step_ack, abort,
        input  step_req, inner_ld, inner_last, outer_last, busy, done, irq
    );

    modport slave (
        input  start, inner_cnt, outer_cnt, step_ack, abort,
        output step_req, inner_ld, inner_last, outer_last, busy, done, irq
    );
endinterface

// File: rtl/blit_loop_sequencer.sv
// ---------------------------------------------------------------------------
// blit_loop_sequencer
// Runs the blitter's nested inner (per-line step) and outer (line) loops.
// A start latches both counts, then one step_req is issued per inner
// iteration. At the end of each inner pass a one-cycle LINE state pulses
// inner_ld, reloads the inner count from a shadow copy and decrements the
// outer count. The final step (or an abort) leads to a one-cycle DONE state
// that pulses done.
//
// Ports:
//   MasterClock : system clock, rising edge
//   reset       : synchronous, active-high
//   bus         : blit_loop_sequencer_if.slave
//                 in : start, inner_cnt, outer_cnt, step_ack, abort
//                 out: step_req, inner_ld, inner_last, outer_last,
//                      busy, done, irq
//
// Build option:
//   BLIT_LOOP_IRQ_EN : when defined, irq is a sticky completion flag set on
//                      the DONE cycle and cleared by the next accepted start.
//                      When undefined, irq is tied low.
// ---------------------------------------------------------------------------
module blit_loop_sequencer #(
    parameter int INNER_W = 9,
    parameter int OUTER_W = 8
) (
    input  logic MasterClock,
    input  logic reset,
    blit_loop_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LINE = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_reg;
    logic [INNER_W-1:0] inner_reg;
    logic [INNER_W-1:0] shadow_reg;
    logic [OUTER_W-1:0] outer_reg;
    logic               step_req_reg;
    logic               inner_ld_reg;
    logic               busy_reg;
    logic               done_reg;

    logic               inner_one;
    logic               outer_one;
    logic [INNER_W-1:0] inner_borrow;
    logic [INNER_W-1:0] inner_dec;
    logic [OUTER_W-1:0] outer_borrow;
    logic [OUTER_W-1:0] outer_dec;

    assign inner_one = (inner_reg == INNER_W'(1));
    assign outer_one = (outer_reg == OUTER_W'(1));

    // Decrement built bit by bit as a borrow-ripple chain: a bit toggles
    // when every lower bit is zero. Zero wraps to all-ones, which is what
    // gives a loaded 0 its 2^W iteration meaning.
    genvar gi;

    assign inner_borrow[0] = 1'b1;
    for (gi = 0; gi < INNER_W; gi++) begin : g_inner_bit
        assign inner_dec[gi] = inner_reg[gi] ^ inner_borrow[gi];
        if (gi < INNER_W - 1) begin : g_chain
            assign inner_borrow[gi+1] = inner_borrow[gi] & ~inner_reg[gi];
        end
    end

    assign outer_borrow[0] = 1'b1;
    for (gi = 0; gi < OUTER_W; gi++) begin : g_outer_bit
        assign outer_dec[gi] = outer_reg[gi] ^ outer_borrow[gi];
        if (gi < OUTER_W - 1) begin : g_chain
            assign outer_borrow[gi+1] = outer_borrow[gi] & ~outer_reg[gi];
        end
    end

    // Control FSM with its outputs registered alongside the state so that
    // step_req/inner_ld/busy/done are glitch-free decodes of the new state.
    always_ff @(posedge MasterClock) begin
        if (reset) begin
            state_reg    <= IDLE;
            inner_reg    <= '0;
            shadow_reg   <= '0;
            outer_reg    <= '0;
            step_req_reg <= 1'b0;
            inner_ld_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            inner_ld_reg <= 1'b0;
            done_reg     <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        inner_reg    <= bus.inner_cnt;
                        shadow_reg   <= bus.inner_cnt;
                        outer_reg    <= bus.outer_cnt;
                        state_reg    <= RUN;
                        step_req_reg <= 1'b1;
                        busy_reg     <= 1'b1;
                    end
                end
                RUN: begin
                    // Abort takes the transition even when an ack arrives in
                    // the same cycle; the counters are left frozen.
                    if (bus.abort) begin
                        state_reg    <= DONE;
                        step_req_reg <= 1'b0;
                        busy_reg     <= 1'b0;
                        done_reg     <= 1'b1;
                    end else if (bus.step_ack) begin
                        if (!inner_one) begin
                            inner_reg <= inner_dec;
                        end else if (!outer_one) begin
                            state_reg    <= LINE;
                            step_req_reg <= 1'b0;
                            inner_ld_reg <= 1'b1;
                        end else begin
                            state_reg    <= DONE;
                            step_req_reg <= 1'b0;
                            busy_reg     <= 1'b0;
                            done_reg     <= 1'b1;
                        end
                    end
                end
                LINE: begin
                    if (bus.abort) begin
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        inner_reg    <= shadow_reg;
                        outer_reg    <= outer_dec;
                        state_reg    <= RUN;
                        step_req_reg <= 1'b1;
                    end
                end
                default: begin
                    // DONE lasts one cycle; start here is dropped.
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.step_req   = step_req_reg;
    assign bus.inner_ld   = inner_ld_reg;
    assign bus.busy       = busy_reg;
    assign bus.done       = done_reg;
    assign bus.inner_last = (state_reg == RUN) && inner_one;
    assign bus.outer_last = (state_reg == RUN) && outer_one;

`ifdef BLIT_LOOP_IRQ_EN
    logic irq_reg;
    logic enter_done;

    // Same conditions that move the FSM into DONE, so irq is already high
    // during the DONE cycle itself.
    assign enter_done = ((state_reg == RUN) &&
                         (bus.abort || (bus.step_ack && inner_one && outer_one))) ||
                        ((state_reg == LINE) && bus.abort);

    always_ff @(posedge MasterClock) begin
        if (reset) begin
            irq_reg <= 1'b0;
        end else if (enter_done) begin
            irq_reg <= 1'b1;
        end else if ((state_reg == IDLE) && bus.start) begin
            irq_reg <= 1'b0;
        end
    end

    assign bus.irq = irq_reg;
`else
    assign bus.irq = 1'b0;
`endif

endmodule

// File: tb/tb_blit_loop_sequencer.sv
// ---------------------------------------------------------------------------
// tb_blit_loop_sequencer
// Scoreboard bench: each blit pushes its expected event sequence (steps with
// their inner_last/outer_last flags, inner-pass reloads, done) and a monitor
// on the falling edge pops and compares as the sequencer produces them.
// ---------------------------------------------------------------------------
module tb_blit_loop_sequencer;
    localparam int INNER_W = 9;
    localparam int OUTER_W = 8;

`ifdef BLIT_LOOP_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    localparam int EV_STEP = 0;
    localparam int EV_LINE = 1;
    localparam int EV_DONE = 2;

    typedef struct {
        int   kind;
        logic il;
        logic ol;
    } exp_t;

    logic MasterClock = 1'b0;
    logic reset       = 1'b1;

    always #5 MasterClock = ~MasterClock;

    blit_loop_sequencer_if #(.INNER_W(INNER_W), .OUTER_W(OUTER_W)) bus();

    blit_loop_sequencer #(.INNER_W(INNER_W), .OUTER_W(OUTER_W)) dut (
        .MasterClock (MasterClock),
        .reset       (reset),
        .bus         (bus)
    );

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    exp_t exp_q[$];

    bit   mon_en    = 1'b0;
    int   done_cnt  = 0;
    int   done_cyc  = 0;
    int   drop_cnt  = 0;
    bit   prev_wait = 1'b0;

    always @(posedge MasterClock) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic pop_cmp(input int kind, input logic il, input logic ol);
        exp_t e;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = '{kind: -1, il: 1'b0, ol: 1'b0};
        check_val("event_kind", kind, e.kind);
        if (kind == EV_STEP && e.kind == EV_STEP) begin
            check_val("inner_last", il, e.il);
            check_val("outer_last", ol, e.ol);
        end
    endtask

    always @(negedge MasterClock) begin
        if (mon_en) begin
            if (bus.step_req && bus.step_ack) pop_cmp(EV_STEP, bus.inner_last, bus.outer_last);
            if (bus.inner_ld) pop_cmp(EV_LINE, 1'b0, 1'b0);
            if (bus.done) begin
                pop_cmp(EV_DONE, 1'b0, 1'b0);
                done_cnt++;
                done_cyc = cyc;
                check_val("busy_in_done", bus.busy, 0);
                check_val("irq_in_done", bus.irq, IRQ_ON);
            end
            if (prev_wait && !bus.step_req) drop_cnt++;
            prev_wait = bus.step_req && !bus.step_ack && !bus.abort;
        end
    end

    task automatic check_idle(input string tag);
        check_val({tag, "_step_req"}, bus.step_req, 0);
        check_val({tag, "_inner_ld"}, bus.inner_ld, 0);
        check_val({tag, "_inner_last"}, bus.inner_last, 0);
        check_val({tag, "_outer_last"}, bus.outer_last, 0);
        check_val({tag, "_busy"}, bus.busy, 0);
        check_val({tag, "_done"}, bus.done, 0);
        check_val({tag, "_irq"}, bus.irq, 0);
    endtask

    // One blit: push the expected event list, start, drive acks every
    // 'period' cycles, optionally abort together with ack number abort_at,
    // optionally try a start during DONE. exp_len < 0 skips the latency check.
    task automatic run_blit(input int inn, input int out, input int period,
                            input int abort_at, input int exp_len, input bit start_in_done);
        int  ni, no, n, ackn, start_cyc, guard;
        bit  stop;
        ni   = (inn == 0) ? (1 << INNER_W) : inn;
        no   = (out == 0) ? (1 << OUTER_W) : out;
        n    = 0;
        stop = 1'b0;
        for (int o = 1; o <= no && !stop; o++) begin
            for (int i = 1; i <= ni && !stop; i++) begin
                n++;
                exp_q.push_back('{kind: EV_STEP, il: (i == ni), ol: (o == no)});
                if (n == abort_at) stop = 1'b1;
            end
            if (!stop && o < no) exp_q.push_back('{kind: EV_LINE, il: 1'b0, ol: 1'b0});
        end
        exp_q.push_back('{kind: EV_DONE, il: 1'b0, ol: 1'b0});

        done_cnt  = 0;
        drop_cnt  = 0;
        prev_wait = 1'b0;
        ackn      = 0;

        @(posedge MasterClock); #1;
        bus.start     = 1'b1;
        bus.inner_cnt = INNER_W'(inn);
        bus.outer_cnt = OUTER_W'(out);
        bus.step_ack  = 1'b0;
        bus.abort     = 1'b0;
        start_cyc     = cyc;
        @(posedge MasterClock); #1;
        bus.start     = 1'b0;
        bus.inner_cnt = ~INNER_W'(inn);
        bus.outer_cnt = ~OUTER_W'(out);
        check_val("irq_clr_on_start", bus.irq, 0);
        check_val("busy_after_start", bus.busy, 1);

        guard = 0;
        while (done_cnt == 0 && guard < 3000) begin
            bus.step_ack = (period <= 1) || (cyc % period == 0);
            bus.abort    = 1'b0;
            if (bus.step_req && bus.step_ack) begin
                ackn++;
                bus.abort = (ackn == abort_at);
            end
            bus.start = start_in_done && bus.done;
            @(posedge MasterClock); #1;
            guard++;
        end
        // Covers the case where done landed in the final driven cycle.
        if (start_in_done && bus.done) begin
            bus.start = 1'b1;
            @(posedge MasterClock); #1;
        end
        bus.start = 1'b0;

        // Stray acks and an abort while idle must not produce anything.
        for (int k = 0; k < 5; k++) begin
            bus.step_ack = k[0];
            bus.abort    = (k == 2);
            @(posedge MasterClock); #1;
        end
        bus.step_ack = 1'b0;
        bus.abort    = 1'b0;

        check_val("done_count", done_cnt, 1);
        check_val("queue_left", exp_q.size(), 0);
        check_val("req_drop", drop_cnt, 0);
        check_val("busy_after", bus.busy, 0);
        if (exp_len >= 0) check_val("latency", done_cyc - start_cyc, exp_len);
        $display("blit inner=%0d outer=%0d period=%0d abort_at=%0d acks=%0d done_cyc=%0d",
                 inn, out, period, abort_at, ackn, done_cyc - start_cyc);
        exp_q.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int guard;
        bus.start     = 1'b0;
        bus.inner_cnt = '0;
        bus.outer_cnt = '0;
        bus.step_ack  = 1'b0;
        bus.abort     = 1'b0;

        repeat (3) @(posedge MasterClock);
        #1;
        check_idle("reset");
        reset = 1'b0;

        // Reset in the middle of a 5x3 blit after four acked steps.
        @(posedge MasterClock); #1;
        bus.start     = 1'b1;
        bus.inner_cnt = INNER_W'(5);
        bus.outer_cnt = OUTER_W'(3);
        bus.step_ack  = 1'b1;
        @(posedge MasterClock); #1;
        bus.start = 1'b0;
        n = 0;
        guard = 0;
        while (n < 4 && guard < 50) begin
            if (bus.step_req) n++;
            @(posedge MasterClock); #1;
            guard++;
        end
        check_val("mid_busy", bus.busy, 1);
        reset = 1'b1;
        @(posedge MasterClock); #1;
        reset = 1'b0;
        bus.step_ack = 1'b0;
        check_idle("mid_rst");
        @(posedge MasterClock); #1;
        check_val("mid_rst_stay_idle", bus.busy, 0);
        $display("mid-blit reset after %0d steps", n);

        mon_en = 1'b1;
        run_blit(3, 2, 1, 0, 8, 1'b0);
        run_blit(0, 1, 1, 0, 513, 1'b0);
        run_blit(2, 2, 3, 0, -1, 1'b0);
        run_blit(4, 4, 1, 2, 3, 1'b1);

        // Completion flag: set on DONE, held while idle, cleared by start.
        run_blit(1, 1, 1, 0, 2, 1'b0);
        repeat (3) @(posedge MasterClock);
        #1;
        check_val("irq_hold", bus.irq, IRQ_ON);
        run_blit(1, 1, 1, 0, 2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/blit_loop_sequencer.md
Name: blit_loop_sequencer

Overview:
- Sequences the blitter's nested inner/outer step counters, which are built from loadable ripple-counter bits.
- Loads both counts on a start request and issues one step request per inner iteration to the blitter datapath.
- Reloads the inner count at the end of each inner pass and decrements the outer count.
- Reports completion with a done pulse. Sits between the blitter command registers and the address/data step logic.

Parameters:
INNER_W, 9, width of inner (per-line) step count
OUTER_W, 8, width of outer (line) count

Ports:
MasterClock  input  1  system clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request to begin a blit; ignored while busy
inner_cnt  input  INNER_W  inner iterations per outer pass; 0 means 2^INNER_W
outer_cnt  input  OUTER_W  outer passes; 0 means 2^OUTER_W
step_ack  input  1  datapath has completed the current inner step
abort  input  1  terminate blit at next cycle
step_req  output  1  request datapath to perform one inner step
inner_ld  output  1  one-cycle pulse: datapath reloads per-line state (end of inner pass)
inner_last  output  1  current step is the final step of the inner pass
outer_last  output  1  current pass is the final outer pass
busy  output  1  high from cycle after accepted start until return to IDLE
done  output  1  one-cycle pulse on normal completion or abort
irq  output  1  completion interrupt (see Optional Feature)

Behaviour:
- Reset: state=IDLE; inner/outer counters=0; step_req, inner_ld, inner_last, outer_last, busy, done, irq all 0. Reset overrides every other input, including mid-blit.
- Count latching: counts are captured into the counter registers (inner_cnt into the inner counter, outer_cnt into the outer counter) on the cycle start is accepted. The inner reload value is held in a shadow register for the whole blit. Input changes after acceptance have no effect.
- States:
  - IDLE: busy=0. On start, latch counts and go to RUN.
  - RUN: step_req=1. On step_ack:
    - inner counter > 1 (or 0 encoding 2^W, not yet started): decrement inner counter, stay in RUN.
    - inner counter == 1 and outer counter != 1: go to LINE.
    - inner counter == 1 and outer counter == 1: go to DONE.
  - LINE: exactly one cycle. step_req=0, inner_ld=1, inner counter reloaded from shadow, outer counter decremented; next state RUN.
  - DONE: exactly one cycle. done=1, busy=0 in this cycle; next state IDLE.
- Decrement arithmetic: modulo 2^W. A value of 0 decrements to all-ones, which gives the 2^W iteration semantics.
- Flags (combinational from state and counters, valid only in RUN):
  - inner_last = (inner counter == 1).
  - outer_last = (outer counter == 1).
- Handshake:
  - step_req stays high while waiting; step_ack without step_req is ignored.
  - Back-to-back acks give one step per cycle.
  - Minimum blit (1x1): start at cycle 0; RUN cycles 1..n; DONE one cycle after the ack cycle.
- abort:
  - In RUN or LINE: go to DONE next cycle; counters freeze.
  - In IDLE or DONE: ignored.
  - abort together with step_ack: the ack is consumed, abort wins the state transition.
- start while busy or in DONE: ignored, not queued.

Optional Feature:
- Macro BLIT_LOOP_IRQ_EN, defined:
  - irq sets on the DONE cycle and stays high until the next accepted start or reset.
  - If start arrives on the same cycle irq would set, set wins.
- Macro undefined: irq tied to 0; no extra flop.

Test Plan:
- Reset mid-RUN (inner=5, outer=3, after 4 acks) -> next cycle state IDLE, all outputs 0, busy=0, counters 0.
- start with inner=3, outer=2, step_ack held high -> 3 step_req cycles, one inner_ld pulse, 3 more steps, done pulse. Cycle accounting: 1 start + 3 steps + 1 LINE + 3 steps + 1 DONE; inner_last high on steps 3 and 6, outer_last high on steps 4-6.
- inner=0, outer=1, ack every cycle -> exactly 512 acked steps, then done; no inner_ld.
- inner=2, outer=2, step_ack every third cycle -> step_req never drops between acks; total 4 steps; extra acks outside RUN ignored.
- abort asserted together with 2nd step_ack of an inner=4, outer=4 blit -> DONE next cycle; done pulses once; start during DONE ignored.
- With BLIT_LOOP_IRQ_EN: 1x1 blit -> irq rises on the DONE cycle, stays 1, clears on the next accepted start. Without the macro: irq stays 0 throughout.
